// File: rtl/toysram_scan_ctl.sv
// rtl/toysram_scan_ctl.sv - scan sequencer for the toy-SRAM 128-bit test chain
// Shifts a latched value through the chain, captures scan_do, and optionally re-shifts to verify.
module toysram_scan_ctl #(
   parameter int SCAN_LEN = 128,
   parameter int HALF_PER = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                mode_i,
   input  logic [SCAN_LEN-1:0] load_val_i,
   input  logic                abort_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                aborted_o,
   output logic                mismatch_o,
   output logic [SCAN_LEN-1:0] out_val_o,
   output logic                te_o,
   output logic                scan_clk_o,
   output logic                scan_di_o,
   input  logic                scan_do_i
);
   localparam int TW = (HALF_PER < 2) ? 1 : $clog2(HALF_PER);
   localparam int BW = $clog2(SCAN_LEN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_LOW   = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   if (HALF_PER < 2) begin : g_half_per_chk
      $error("HALF_PER must be 2 or more");
   end

   logic [2:0]          state_q, state_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic                pass_q, pass_d;
   logic                mode_q, mode_d;
   logic [SCAN_LEN-1:0] sr_q, sr_d;
   logic [SCAN_LEN-1:0] lat_q, lat_d;
   logic [SCAN_LEN-1:0] out_q, out_d;
   logic                aborted_q, aborted_d;
   logic                mismatch_q, mismatch_d;
   logic                last_tick;

   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      pass_d     = pass_q;
      mode_d     = mode_q;
      sr_d       = sr_q;
      lat_d      = lat_q;
      out_d      = out_q;
      aborted_d  = aborted_q;
      mismatch_d = mismatch_q;
      last_tick  = (tmr_q == TW'(HALF_PER - 1));
      tmr_d      = last_tick ? '0 : tmr_q + 1'b1;
      case (state_q)
         S_IDLE, S_DONE: begin
            tmr_d   = '0;
            state_d = S_IDLE;
            if (start_i) begin
               state_d    = S_SETUP;
               sr_d       = load_val_i;
               lat_d      = load_val_i;
               mode_d     = mode_i;
               out_d      = '0;
               mismatch_d = 1'b0;
               aborted_d  = 1'b0;
               bit_d      = '0;
               pass_d     = 1'b0;
            end
         end
         S_SETUP, S_LOW: begin
            // abort beats the capture on the final LOW cycle, so out_val holds only completed bits
            if (abort_i) begin
               state_d   = S_HOLD;
               tmr_d     = '0;
               aborted_d = 1'b1;
            end else if (last_tick) begin
               if (state_q == S_LOW) begin
                  out_d   = {out_q[SCAN_LEN-2:0], scan_do_i};
                  state_d = S_HIGH;
               end else begin
                  state_d = S_LOW;
               end
            end
         end
         S_HIGH: begin
            if (abort_i) aborted_d = 1'b1;
            if (last_tick) begin
               sr_d    = {sr_q[SCAN_LEN-2:0], 1'b0};
               bit_d   = bit_q + 1'b1;
               state_d = S_LOW;
               if (abort_i || aborted_q) begin
                  state_d = S_HOLD;
               end else if (bit_q == BW'(SCAN_LEN - 1)) begin
                  if (mode_q && !pass_q) begin
                     pass_d = 1'b1;
                     bit_d  = '0;
                     sr_d   = lat_q;
                     out_d  = '0;
                  end else begin
                     state_d = S_HOLD;
                  end
               end
            end
         end
         S_HOLD: begin
            if (last_tick) begin
               state_d    = S_DONE;
               mismatch_d = mode_q && !aborted_q && (out_q != lat_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         bit_q      <= '0;
         pass_q     <= 1'b0;
         mode_q     <= 1'b0;
         sr_q       <= '0;
         lat_q      <= '0;
         out_q      <= '0;
         aborted_q  <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bit_q      <= bit_d;
         pass_q     <= pass_d;
         mode_q     <= mode_d;
         sr_q       <= sr_d;
         lat_q      <= lat_d;
         out_q      <= out_d;
         aborted_q  <= aborted_d;
         mismatch_q <= mismatch_d;
      end
   end

   // pin outputs decode the state flops directly so reset drops them asynchronously
   assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign te_o       = busy_o;
   assign done_o     = (state_q == S_DONE);
   assign scan_clk_o = (state_q == S_HIGH);
   assign scan_di_o  = ((state_q == S_LOW) || (state_q == S_HIGH)) && sr_q[SCAN_LEN-1];
   assign aborted_o  = aborted_q;
   assign mismatch_o = mismatch_q;
   assign out_val_o  = out_q;
endmodule

// File: tb/tb_toysram_scan_ctl.sv
// tb/tb_toysram_scan_ctl.sv - randomized self-checking bench for toysram_scan_ctl
// Two instances (HALF_PER 4 and 2) share one behavioural scan chain selected by sel.
module tb_toysram_scan_ctl;
   localparam int L   = 128;
   localparam int HP1 = 4;
   localparam int HP2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, sel, st, md, ab;
   logic [L-1:0] ld;
   logic [L-1:0] chain;
   logic         scan_do;
   assign scan_do = chain[L-1];

   logic         busy1, done1, abrt1, mism1, te1, sclk1, sdi1;
   logic         busy2, done2, abrt2, mism2, te2, sclk2, sdi2;
   logic [L-1:0] out1, out2;

   toysram_scan_ctl #(.SCAN_LEN(L), .HALF_PER(HP1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st & ~sel), .mode_i(md), .load_val_i(ld),
      .abort_i(ab & ~sel), .busy_o(busy1), .done_o(done1), .aborted_o(abrt1),
      .mismatch_o(mism1), .out_val_o(out1), .te_o(te1), .scan_clk_o(sclk1),
      .scan_di_o(sdi1), .scan_do_i(scan_do));

   toysram_scan_ctl #(.SCAN_LEN(L), .HALF_PER(HP2)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st & sel), .mode_i(md), .load_val_i(ld),
      .abort_i(ab & sel), .busy_o(busy2), .done_o(done2), .aborted_o(abrt2),
      .mismatch_o(mism2), .out_val_o(out2), .te_o(te2), .scan_clk_o(sclk2),
      .scan_di_o(sdi2), .scan_do_i(scan_do));

   logic         m_busy, m_done, m_abrt, m_mism, m_te, m_sclk, m_sdi;
   logic [L-1:0] m_out;
   assign m_busy = sel ? busy2 : busy1;
   assign m_done = sel ? done2 : done1;
   assign m_abrt = sel ? abrt2 : abrt1;
   assign m_mism = sel ? mism2 : mism1;
   assign m_te   = sel ? te2   : te1;
   assign m_sclk = sel ? sclk2 : sclk1;
   assign m_sdi  = sel ? sdi2  : sdi1;
   assign m_out  = sel ? out2  : out1;

   // Faulty chain: cell 64 reads back 1 whenever the chain is parked after a whole pass.
   logic         sclk_prev = 1'b0;
   logic         preload_req, fault_en;
   logic [L-1:0] preload_val;
   int           chain_rises = 0;

   function automatic logic [L-1:0] shift_chain(input logic [L-1:0] c, input logic di,
                                                input logic fault, input int n);
      logic [L-1:0] r;
      r = {c[L-2:0], di};
      if (fault && (n % L == 0)) r[64] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      sclk_prev <= m_sclk;
      if (preload_req) begin
         chain       <= preload_val;
         chain_rises <= 0;
      end else if (m_sclk && !sclk_prev) begin
         chain       <= shift_chain(chain, m_sdi, fault_en, chain_rises + 1);
         chain_rises <= chain_rises + 1;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkv(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic seq_bit(input logic [L-1:0] v, input int j);
      int idx;
      idx = L - 1 - (j % L);
      return v[idx];
   endfunction

   int           e, hp, np, hold_start, done_e, pulses, rises, obs_done;
   logic         tb_prev_sclk, x_abrt, x_mism;
   logic [L-1:0] c_load, shadow, x_out;

   // Expected pins from elapsed cycles: phase p = (e-1)/hp; 0 setup, odd low, even high.
   task automatic check_cycle();
      int   p;
      logic lo, hi;
      p  = (e - 1) / hp;
      lo = (p >= 1) && (p <= 2 * np) && (p % 2 == 1) && (e < hold_start);
      hi = (p >= 1) && (p <= 2 * np) && (p % 2 == 0) && (e < hold_start);
      chk1("busy", m_busy, e < done_e);
      chk1("te", m_te, e < done_e);
      chk1("done", m_done, e == done_e);
      chk1("scan_clk", m_sclk, hi);
      if (lo || hi) chk1("scan_di", m_sdi, seq_bit(c_load, (p - 1) / 2));
      if (m_sclk && !tb_prev_sclk) rises++;
      if (m_done && obs_done == 0) obs_done = e;
      tb_prev_sclk = m_sclk;
   endtask

   task automatic run_cmd(input logic mode, input logic [L-1:0] val, input int ea,
                          input int es, input int stop_e);
      logic [L-1:0] c, o;
      int           pa;
      hp         = sel ? HP2 : HP1;
      np         = mode ? 2 * L : L;
      hold_start = hp * (1 + 2 * np) + 1;
      pulses     = np;
      x_abrt     = 1'b0;
      if (ea > 0) begin
         pa     = (ea - 1) / hp;
         x_abrt = 1'b1;
         if (pa == 0) begin
            hold_start = ea + 1;
            pulses     = 0;
         end else if (pa % 2 == 1) begin
            hold_start = ea + 1;
            pulses     = (pa - 1) / 2;
         end else begin
            hold_start = (pa + 1) * hp + 1;
            pulses     = pa / 2;
         end
      end
      done_e = hold_start + hp;
      if (es < 2 || es >= done_e) es = 0;
      c = shadow;
      o = '0;
      for (int j = 0; j < pulses; j++) begin
         if (j == L) o = '0;
         o = {o[L-2:0], c[L-1]};
         c = {c[L-2:0], seq_bit(val, j)};
      end
      x_out  = o;
      x_mism = mode && !x_abrt && (o != val);
      c_load = val;
      st = 1'b1; md = mode; ld = val; ab = 1'b0;
      rises = 0; obs_done = 0; tb_prev_sclk = m_sclk;
      e = 0;
      while (e < done_e && !(stop_e > 0 && e == stop_e)) begin
         @(negedge clk);
         e++;
         check_cycle();
         st = (e == es);
         if (st) begin
            md = ~mode;
            ld = ~val;
         end
         ab = (e == ea);
      end
      st = 1'b0; ab = 1'b0;
      if (stop_e == 0 && !fault_en) begin
         chkv("out_val", m_out, x_out);
         chk1("mismatch", m_mism, x_mism);
         chk1("aborted", m_abrt, x_abrt);
         chki("rises", rises, pulses);
         chkv("chain", chain, c);
         shadow = c;
      end
   endtask

   task automatic idle(input int n);
      st = 1'b0; ab = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk1("idle_busy", m_busy, 1'b0);
         chk1("idle_done", m_done, 1'b0);
         chk1("idle_te", m_te, 1'b0);
         chk1("idle_sclk", m_sclk, 1'b0);
      end
   endtask

   task automatic preload(input logic [L-1:0] v);
      @(negedge clk);
      preload_req = 1'b1;
      preload_val = v;
      @(negedge clk);
      preload_req = 1'b0;
      shadow = v;
   endtask

   localparam logic [L-1:0] PAT   = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [L-1:0] BIT64 = {64'h1, 64'h0};

   initial begin
      rst_n = 1'b0; sel = 1'b0; st = 1'b0; md = 1'b0; ab = 1'b0; ld = '0;
      preload_req = 1'b0; fault_en = 1'b0; preload_val = '0; shadow = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("rst_busy", m_busy, 1'b0);
      chk1("rst_done", m_done, 1'b0);
      chk1("rst_aborted", m_abrt, 1'b0);
      chk1("rst_mismatch", m_mism, 1'b0);
      chkv("rst_out_val", m_out, '0);
      chk1("rst_te", m_te, 1'b0);
      chk1("rst_scan_clk", m_sclk, 1'b0);
      chk1("rst_scan_di", m_sdi, 1'b0);
      chk1("rst_busy_hp2", busy2, 1'b0);

      // reset in the middle of a HIGH phase
      preload({$urandom, $urandom, $urandom, $urandom} | 128'h1);
      run_cmd(1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 162);
      rst_n = 1'b0;
      #1;
      chk1("midrst_te", m_te, 1'b0);
      chk1("midrst_scan_clk", m_sclk, 1'b0);
      chk1("midrst_busy", m_busy, 1'b0);
      chk1("midrst_done", m_done, 1'b0);
      chkv("midrst_out_val", m_out, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(20);

      // exchange pair on a zeroed chain, back to back, with an ignored start mid-command
      preload('0);
      run_cmd(1'b0, PAT, 0, 0, 0);
      chkv("xchg1_out", m_out, '0);
      chki("xchg1_done_cycle", obs_done, 1033);
      chki("xchg1_rises", rises, 128);
      run_cmd(1'b0, ~PAT, 0, 600, 0);
      chkv("xchg2_out", m_out, PAT);
      chki("xchg2_rises", rises, 128);
      idle(3);

      run_cmd(1'b1, PAT, 0, 0, 0);
      chkv("verify_out", m_out, PAT);
      chk1("verify_mismatch", m_mism, 1'b0);
      chki("verify_rises", rises, 256);
      chki("verify_done_cycle", obs_done, 2057);
      idle(3);

      run_cmd(1'b0, {$urandom, $urandom, $urandom, $urandom}, 90, 0, 0);
      chki("abort_rises", rises, 11);
      chki("abort_done_cycle", obs_done, 97);
      chk1("abort_flag", m_abrt, 1'b1);
      chk1("abort_te_at_done", m_te, 1'b0);
      idle(3);

      fault_en = 1'b1;
      preload(BIT64);
      run_cmd(1'b1, '0, 0, 0, 0);
      chk1("fault_mismatch", m_mism, 1'b1);
      chkv("fault_out", m_out, BIT64);
      chki("fault_rises", rises, 256);
      fault_en = 1'b0;
      preload('0);

      for (int k = 0; k < 12; k++) begin
         logic         rm;
         logic [L-1:0] rv;
         int           ra, rs, rn;
         rm = 1'($urandom_range(0, 1));
         rv = {$urandom, $urandom, $urandom, $urandom};
         rn = rm ? 2 * L : L;
         ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, HP1 * (1 + 2 * rn))) : 0;
         rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 1000)) : 0;
         run_cmd(rm, rv, ra, rs, 0);
         if (k % 2 == 1) idle(3);
      end
      idle(3);

      sel = 1'b1;
      idle(2);
      run_cmd(1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
      chki("hp2_done_cycle", obs_done, 517);
      chki("hp2_rises", rises, 128);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
